// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of a single down-counting timer.
// A granted requester's delay is latched, the timer is loaded for one cycle,
// then enabled until timeout, after which a one-cycle done pulse is returned.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   io_req[NREQ]        request levels, held until the matching io_done
//   io_reqDelay         packed per-requester delays, WIDTH bits each
//   io_irqEnable[NREQ]  per-requester interrupt enable
//   io_grant[NREQ]      one-hot current owner, zero when idle
//   io_done[NREQ]       one-hot completion pulse
//   io_irq              done gated by the owner's interrupt enable
//   io_busy             controller not idle
//   io_tmrEnable        timer enable (low = timer loads io_tmrLoad)
//   io_tmrLoad          registered timer load value
//   io_tmrTimeout       timer reached zero while enabled
//   io_tmrValue         timer count, observation only
module timer_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       io_req,
  input  logic [NREQ*WIDTH-1:0] io_reqDelay,
  input  logic [NREQ-1:0]       io_irqEnable,
  output logic [NREQ-1:0]       io_grant,
  output logic [NREQ-1:0]       io_done,
  output logic                  io_irq,
  output logic                  io_busy,
  output logic                  io_tmrEnable,
  output logic [WIDTH-1:0]      io_tmrLoad,
  input  logic                  io_tmrTimeout,
  input  logic [WIDTH-1:0]      io_tmrValue
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  load_q, load_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand_idx;
  int                cand;
  logic [WIDTH-1:0]  pick_delay;
  logic [IdxW-1:0]   owner_inc;
  logic [NREQ-1:0]   owner_oh;

  // Timer count is only for external observation.
  logic unused_tmr_value;
  assign unused_tmr_value = ^io_tmrValue;

  // Search upward from ptr with wrap; walking the offsets downward lets the
  // smallest offset (closest to ptr) be the last and therefore winning write.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
      cand_idx = IdxW'(cand);
      if (io_req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pick_delay = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IdxW'(i) == pick_idx) pick_delay = io_reqDelay[i*WIDTH +: WIDTH];
    end
  end

  assign owner_inc = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    load_d  = load_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          load_d  = pick_delay;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!io_req[owner_q]) begin
          state_d = StIdle;
          ptr_d   = owner_inc;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A dropped request wins over a same-cycle timeout.
        if (!io_req[owner_q]) begin
          state_d = StIdle;
          ptr_d   = owner_inc;
        end else if (io_tmrTimeout) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = owner_inc;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      load_q  <= load_d;
    end
  end

  assign owner_oh     = NREQ'(1) << owner_q;
  assign io_grant     = (state_q != StIdle) ? owner_oh : '0;
  assign io_done      = (state_q == StDone) ? owner_oh : '0;
  assign io_irq       = |(io_done & io_irqEnable);
  assign io_busy      = (state_q != StIdle);
  assign io_tmrEnable = (state_q == StRun);
  assign io_tmrLoad   = load_q;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_delay;
  logic [NREQ-1:0]       irq_en;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  irq;
  logic                  busy;
  logic                  tmr_en;
  logic [WIDTH-1:0]      tmr_load;
  logic                  tmr_timeout;
  logic [WIDTH-1:0]      tmr_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_req       (req),
    .io_reqDelay  (req_delay),
    .io_irqEnable (irq_en),
    .io_grant     (grant),
    .io_done      (done),
    .io_irq       (irq),
    .io_busy      (busy),
    .io_tmrEnable (tmr_en),
    .io_tmrLoad   (tmr_load),
    .io_tmrTimeout(tmr_timeout),
    .io_tmrValue  (tmr_cnt)
  );

  // Reference timer: load while disabled, count down to zero while enabled.
  always @(posedge clk) begin
    if (!tmr_en) tmr_cnt <= tmr_load;
    else if (tmr_cnt != 0) tmr_cnt <= tmr_cnt - 1;
  end
  assign tmr_timeout = tmr_en && (tmr_cnt == 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_delay(input int idx, input logic [WIDTH-1:0] d);
    req_delay[idx*WIDTH +: WIDTH] = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_en"}, tmr_en, 0);
  endtask

  task automatic expect_load(input int idx, input logic [WIDTH-1:0] d);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    tick();
    check("load_grant", grant, oh);
    check("load_busy", busy, 1);
    check("load_en", tmr_en, 0);
    check("load_done", done, 0);
    check("load_value", tmr_load, d);
  endtask

  task automatic expect_run(input int idx, input int d, input int n);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    for (int i = 0; i < n; i++) begin
      tick();
      check("run_en", tmr_en, 1);
      check("run_grant", grant, oh);
      check("run_done", done, 0);
      check("run_count", tmr_cnt, d - i);
      check("run_timeout", tmr_timeout, (i == d));
    end
  endtask

  task automatic expect_done(input int idx, input logic irq_exp);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    tick();
    check("done_pulse", done, oh);
    check("done_grant", grant, oh);
    check("done_irq", irq, irq_exp);
    check("done_en", tmr_en, 0);
    check("done_busy", busy, 1);
  endtask

  initial begin
    int found;
    int last;
    logic [NREQ-1:0] exp_oh;

    reset     = 1'b1;
    req       = '0;
    req_delay = '0;
    irq_en    = '0;
    tick();
    tick();
    check_idle("rst");
    check("rst_load", tmr_load, 0);

    // Round-robin: all requesters pending out of reset, delay 2 each.
    for (int i = 0; i < NREQ; i++) set_delay(i, 2);
    req = 4'b1111;
    tick();
    reset = 1'b0;
    tick();
    check("rr_first_grant", grant, 4'b0001);
    last = 0;
    for (int n = 0; n < 5; n++) begin
      found = 0;
      for (int j = 0; j < 20 && found == 0; j++) begin
        tick();
        if (done != 0) found = 1;
      end
      check("rr_done_seen", found, 1);
      exp_oh = NREQ'(1) << (n % NREQ);
      check("rr_done_owner", done, exp_oh);
      if (n > 0) check("rr_done_spacing", cyc - last, 6);
      last = cyc;
    end
    req = '0;
    tick();
    check_idle("rr_end");

    // Single request, delay 5, interrupt enabled.
    set_delay(0, 5);
    irq_en = 4'b0001;
    req    = 4'b0001;
    expect_load(0, 5);
    expect_run(0, 5, 6);
    expect_done(0, 1'b1);
    req = '0;
    tick();
    check_idle("single_end");

    // Zero delay, with and without interrupt enable.
    set_delay(2, 0);
    irq_en = 4'b0100;
    req    = 4'b0100;
    expect_load(2, 0);
    expect_run(2, 0, 1);
    expect_done(2, 1'b1);
    req = '0;
    tick();
    irq_en = 4'b0000;
    req    = 4'b0100;
    expect_load(2, 0);
    expect_run(2, 0, 1);
    expect_done(2, 1'b0);
    req = '0;
    tick();
    check_idle("zero_end");

    // Delay changed during LOAD must not affect the run.
    set_delay(0, 8);
    req = 4'b0001;
    expect_load(0, 8);
    set_delay(0, 3);
    expect_run(0, 8, 9);
    expect_done(0, 1'b0);
    req = '0;
    tick();
    check_idle("dchg_end");

    // Abort in RUN cycle 20; requester 3 must win over 0 (ptr = 2).
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_delay(1, 100);
    set_delay(3, 7);
    req = 4'b1010;
    expect_load(1, 100);
    expect_run(1, 100, 21);
    req = 4'b1001;
    tick();
    check_idle("abort_idle");
    expect_load(3, 7);

    // Reset mid-RUN after ptr has moved to 2.
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    set_delay(1, 1);
    req = 4'b0010;
    expect_load(1, 1);
    expect_run(1, 1, 2);
    expect_done(1, 1'b0);
    req = '0;
    tick();
    set_delay(2, 50);
    req = 4'b0100;
    expect_load(2, 50);
    expect_run(2, 50, 11);
    reset = 1'b1;
    tick();
    check_idle("rstrun");
    check("rstrun_load", tmr_load, 0);
    reset = 1'b0;
    set_delay(0, 4);
    req = 4'b0101;
    expect_load(0, 4);
    req = '0;
    tick();
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
